// File: rtl/pkt_switch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_switch_if : per-port packet buses of the N-port packet switch        |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
interface pkt_switch_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
);
  logic [NUM_PORTS-1:0]        valid_in;
  logic [NUM_PORTS-1:0]        ready_in;
  logic [NUM_PORTS*ADDR_W-1:0] source_in;
  logic [NUM_PORTS*ADDR_W-1:0] target_in;
  logic [NUM_PORTS*DATA_W-1:0] data_in;
  logic [NUM_PORTS-1:0]        valid_out;
  logic [NUM_PORTS-1:0]        ready_out;
  logic [NUM_PORTS*ADDR_W-1:0] source_out;
  logic [NUM_PORTS*ADDR_W-1:0] target_out;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [CNT_W-1:0]            drop_cnt;

  modport master (
    output valid_in, source_in, target_in, data_in, ready_out,
    input  ready_in, valid_out, source_out, target_out, data_out, drop_cnt
  );

  modport slave (
    input  valid_in, source_in, target_in, data_in, ready_out,
    output ready_in, valid_out, source_out, target_out, data_out, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pkt_switch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_switch : N-port packet switch, input FIFOs, round-robin per output   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module pkt_switch #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pkt_switch_if.slave bus
);

  localparam int PKT_W  = 2*ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [PKT_W-1:0]     w_head      [NUM_PORTS];
  logic [ADDR_W-1:0]    w_head_tgt  [NUM_PORTS];
  logic                 w_head_vld  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_grant     [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_drop;
  logic [4:0]           w_drop_num;
  logic [CNT_W+4:0]     w_drop_sum;
  logic [CNT_W-1:0]     r_drop_cnt;

  function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PORT_W'(s);
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [PKT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_fcnt;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_full;
    logic              w_accept;
    logic              w_tgt_ok;
    logic              w_push;
    logic              w_pop;

    assign w_tgt    = bus.target_in[p*ADDR_W +: ADDR_W];
    assign w_full   = (r_fcnt == FCNT_W'(FIFO_DEPTH));
    assign w_accept = bus.valid_in[p] & ~w_full;
    // Extra bit so NUM_PORTS == 2^ADDR_W still compares correctly.
    assign w_tgt_ok = ({1'b0, w_tgt} < (ADDR_W+1)'(NUM_PORTS));
    assign w_push   = w_accept & w_tgt_ok;
    assign w_drop[p] = w_accept & ~w_tgt_ok;

    assign bus.ready_in[p] = ~w_full;
    assign w_head[p]       = r_mem[r_rd_ptr];
    assign w_head_tgt[p]   = r_mem[r_rd_ptr][DATA_W +: ADDR_W];
    assign w_head_vld[p]   = (r_fcnt != '0);

    always_comb begin
      w_pop = 1'b0;
      for (int t = 0; t < NUM_PORTS; t++) w_pop = w_pop | w_grant[t][p];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_fcnt   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_fcnt <= r_fcnt + FCNT_W'(w_push) - FCNT_W'(w_pop);
      end
    end

    always_ff @(posedge clk) begin
      if (rst_n && w_push)
        r_mem[r_wr_ptr] <= {bus.source_in[p*ADDR_W +: ADDR_W], w_tgt,
                            bus.data_in[p*DATA_W +: DATA_W]};
    end
  end

  for (genvar t = 0; t < NUM_PORTS; t++) begin : g_out
    logic [PORT_W-1:0]    r_rr_ptr;
    logic                 r_vo;
    logic [PKT_W-1:0]     r_pkt;
    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any;
    logic [PORT_W-1:0]    w_idx;
    logic                 w_load;

    assign w_load = ~r_vo | bus.ready_out[t];

    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++)
        w_req[p] = w_head_vld[p] && (w_head_tgt[p] == ADDR_W'(t));
    end

    // Descending scan so the requester closest to r_rr_ptr wins last.
    always_comb begin
      w_any = 1'b0;
      w_idx = '0;
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
        if (w_req[wrap_add(r_rr_ptr, i)]) begin
          w_any = 1'b1;
          w_idx = wrap_add(r_rr_ptr, i);
        end
      end
    end

    assign w_grant[t] = (w_load && w_any) ? (NUM_PORTS'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rr_ptr <= '0;
        r_vo     <= 1'b0;
        r_pkt    <= '0;
      end else if (w_load) begin
        if (w_any) begin
          r_vo     <= 1'b1;
          r_pkt    <= w_head[w_idx];
          r_rr_ptr <= wrap_add(w_idx, 1);
        end else begin
          r_vo     <= 1'b0;
        end
      end
    end

    assign bus.valid_out[t]                    = r_vo;
    assign bus.source_out[t*ADDR_W +: ADDR_W]  = r_pkt[DATA_W+ADDR_W +: ADDR_W];
    assign bus.target_out[t*ADDR_W +: ADDR_W]  = r_pkt[DATA_W +: ADDR_W];
    assign bus.data_out[t*DATA_W +: DATA_W]    = r_pkt[DATA_W-1:0];
  end

  always_comb begin
    w_drop_num = '0;
    for (int p = 0; p < NUM_PORTS; p++) w_drop_num = w_drop_num + 5'(w_drop[p]);
  end

  assign w_drop_sum = {5'd0, r_drop_cnt} + {CNT_W'(0), w_drop_num};

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (w_drop_sum > {5'd0, C_CNT_MAX})
      r_drop_cnt <= C_CNT_MAX;
    else
      r_drop_cnt <= w_drop_sum[CNT_W-1:0];
  end

  assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_switch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pkt_switch : directed self-checking bench for pkt_switch              |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_pkt_switch;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int SCW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pkt_switch_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW))  bus0 ();
  pkt_switch_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(SCW)) bus1 ();

  pkt_switch #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  pkt_switch #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int         port;
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] exp_vo;
    int         exp_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.valid_in  = '0;
    bus0.source_in = '0;
    bus0.target_in = '0;
    bus0.data_in   = '0;
  endtask

  task automatic send(input int p, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    bus0.valid_in[p]            = 1'b1;
    bus0.source_in[p*AW +: AW]  = s;
    bus0.target_in[p*AW +: AW]  = t;
    bus0.data_in[p*DW +: DW]    = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus0.ready_out = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  got_src [$];
    logic [7:0]  got_dat [$];
    int          first_c, last_c, n_acc;
    logic [7:0]  prev_drop;
    logic [3:0]  stray;
    logic [15:0] exp_src_bus, exp_tgt_bus;
    logic [31:0] exp_dat_bus;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    bus0.ready_out = '1;
    bus1.valid_in  = '0;
    bus1.source_in = '0;
    bus1.target_in = '0;
    bus1.data_in   = '0;
    bus1.ready_out = '1;

    // Reset values
    tick();
    tick();
    check("rst_ready_in_in_reset", bus0.ready_in, 4'hF);
    rst_n = 1'b1;
    check("rst_valid_out", bus0.valid_out, 4'h0);
    check("rst_drop_cnt", bus0.drop_cnt, 16'h0);
    check("rst_ready_in", bus0.ready_in, 4'hF);
    check("rst_source_out", bus0.source_out, 16'h0);
    check("rst_target_out", bus0.target_out, 16'h0);
    check("rst_data_out", bus0.data_out, 32'h0);

    // Single-packet vectors: one cycle latency, routing and drops
    vecs[0] = '{0, 4'h0, 4'h2, 8'hA5, 4'b0100, 0};
    vecs[1] = '{1, 4'h1, 4'h0, 8'h3C, 4'b0001, 0};
    vecs[2] = '{3, 4'h7, 4'h3, 8'hFF, 4'b1000, 0};
    vecs[3] = '{2, 4'h2, 4'h1, 8'h00, 4'b0010, 0};
    vecs[4] = '{1, 4'h5, 4'h9, 8'h11, 4'b0000, 1};
    vecs[5] = '{0, 4'h0, 4'hF, 8'h22, 4'b0000, 1};
    vecs[6] = '{3, 4'h3, 4'h4, 8'h44, 4'b0000, 1};
    vecs[7] = '{2, 4'h9, 4'h3, 8'h5A, 4'b1000, 0};

    for (int i = 0; i < 8; i++) begin
      prev_drop = bus0.drop_cnt[7:0];
      send(vecs[i].port, vecs[i].src, vecs[i].tgt, vecs[i].data);
      tick();
      clear_inputs();
      check("vec_no_early_valid", bus0.valid_out, 4'h0);
      tick();
      check("vec_valid_out", bus0.valid_out, vecs[i].exp_vo);
      for (int t = 0; t < N; t++) begin
        if (vecs[i].exp_vo[t]) begin
          check("vec_source_out", bus0.source_out[t*AW +: AW], vecs[i].src);
          check("vec_target_out", bus0.target_out[t*AW +: AW], vecs[i].tgt);
          check("vec_data_out", bus0.data_out[t*DW +: DW], vecs[i].data);
        end
      end
      check("vec_drop_cnt", bus0.drop_cnt, 16'(prev_drop) + 16'(vecs[i].exp_drop));
      tick();
      check("vec_valid_cleared", bus0.valid_out, 4'h0);
    end

    // Round-robin fairness: all inputs to output 1
    do_reset();
    first_c = -1;
    last_c  = -1;
    stray   = '0;
    for (int c = 0; c < 20; c++) begin
      clear_inputs();
      if (c < 3) begin
        for (int p = 0; p < N; p++) send(p, 4'(p), 4'd1, {4'(p), 4'(c)});
      end
      tick();
      stray |= bus0.valid_out & 4'b1101;
      if (bus0.valid_out[1]) begin
        got_src.push_back(bus0.source_out[1*AW +: AW]);
        got_dat.push_back(bus0.data_out[1*DW +: DW]);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    clear_inputs();
    check("rr_count", got_src.size(), 12);
    check("rr_first_cycle", first_c, 1);
    check("rr_last_cycle", last_c, 12);
    check("rr_no_stray_outputs", stray, 4'h0);
    for (int i = 0; i < 12; i++) begin
      check("rr_source_order", (i < got_src.size()) ? got_src[i] : 4'hX, 4'(i % 4));
      check("rr_data_order", (i < got_dat.size()) ? got_dat[i] : 8'hXX, {4'(i % 4), 4'(i / 4)});
    end

    // Backpressure on output 3
    do_reset();
    bus0.ready_out = 4'b0111;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus0.ready_in[1]) break;
      send(1, 4'd1, 4'd3, 8'h10 + 8'(n_acc));
      n_acc++;
      tick();
    end
    clear_inputs();
    check("bp_accepts", n_acc, 5);
    check("bp_ready_in_low", bus0.ready_in[1], 1'b0);
    check("bp_valid_held", bus0.valid_out[3], 1'b1);
    check("bp_data_head", bus0.data_out[3*DW +: DW], 8'h10);
    tick();
    tick();
    tick();
    check("bp_data_stable", bus0.data_out[3*DW +: DW], 8'h10);
    check("bp_source_stable", bus0.source_out[3*AW +: AW], 4'd1);
    check("bp_valid_stable", bus0.valid_out[3], 1'b1);
    bus0.ready_out = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_drain_valid", bus0.valid_out[3], 1'b1);
      check("bp_drain_data", bus0.data_out[3*DW +: DW], 8'h10 + 8'(i));
      tick();
    end
    check("bp_drained", bus0.valid_out[3], 1'b0);

    // Drop counting, two on one edge
    do_reset();
    send(0, 4'd0, 4'd9, 8'h01);
    send(2, 4'd2, 4'd9, 8'h02);
    tick();
    clear_inputs();
    check("drop_two_same_edge", bus0.drop_cnt, 16'd2);
    check("drop_no_output", bus0.valid_out, 4'h0);
    tick();
    check("drop_no_output_later", bus0.valid_out, 4'h0);
    check("drop_cnt_holds", bus0.drop_cnt, 16'd2);

    // Saturation on the 4-bit counter instance
    bus1.valid_in  = 4'b0001;
    bus1.target_in = 16'h0009;
    for (int i = 0; i < 10; i++) tick();
    check("sat_count_10", bus1.drop_cnt, 4'd10);
    for (int i = 0; i < 10; i++) tick();
    bus1.valid_in = '0;
    check("sat_count_max", bus1.drop_cnt, 4'd15);
    check("sat_no_output", bus1.valid_out, 4'h0);

    // Reset mid-stream with full outputs and non-empty FIFOs
    do_reset();
    bus0.ready_out = 4'h0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < N; p++) send(p, 4'(p), 4'(p), {4'(p), 4'(k)});
      tick();
    end
    check("mid_all_valid", bus0.valid_out, 4'hF);
    rst_n = 1'b0;
    tick();
    check("mid_valid_cleared", bus0.valid_out, 4'h0);
    check("mid_ready_in", bus0.ready_in, 4'hF);
    check("mid_drop_cnt", bus0.drop_cnt, 16'd0);
    rst_n = 1'b1;
    clear_inputs();
    bus0.ready_out = 4'hF;
    stray = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      stray |= bus0.valid_out;
    end
    check("mid_no_stale", stray, 4'h0);

    // Parallel permutation p -> 3-p
    do_reset();
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      if (c < 8) begin
        for (int p = 0; p < N; p++) send(p, 4'(p), 4'(3 - p), {4'(p), 4'(c)});
      end
      tick();
      if (c >= 1) begin
        for (int t = 0; t < N; t++) begin
          exp_src_bus[t*AW +: AW] = 4'(3 - t);
          exp_tgt_bus[t*AW +: AW] = 4'(t);
          exp_dat_bus[t*DW +: DW] = {4'(3 - t), 4'(c - 1)};
        end
        check("perm_valid_out", bus0.valid_out, 4'hF);
        check("perm_source_out", bus0.source_out, exp_src_bus);
        check("perm_target_out", bus0.target_out, exp_tgt_bus);
        check("perm_data_out", bus0.data_out, exp_dat_bus);
        check("perm_ready_in", bus0.ready_in, 4'hF);
      end
    end
    clear_inputs();
    tick();
    check("perm_idle", bus0.valid_out, 4'h0);
    check("perm_no_drops", bus0.drop_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_switch.md
# pkt_switch

Parametrised N-port packet switch carrying the team's {source, target, data} packet format. Each input port has a FIFO with valid/ready backpressure. Each output port has a registered valid/ready stage, and a per-output round-robin arbiter chooses among input FIFO heads addressed to that output. Packets whose target is out of range are discarded and counted. The block is the DUT behind the per-port packet interfaces in the switch testbench.

## Interface
- NUM_PORTS, 4, number of input and output ports; 2..16 and ≤ 2^ADDR_W
- ADDR_W, 4, width of the source and target fields
- DATA_W, 8, width of the payload
- FIFO_DEPTH, 4, entries per input FIFO; power of two, ≥ 2
- CNT_W, 16, width of the drop counter

Ports (port p occupies bit p of 1-bit vectors and slice [p*W +: W] of wide vectors):
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- valid_in  in  NUM_PORTS  input packet valid
- ready_in  out  NUM_PORTS  input port can accept
- source_in  in  NUM_PORTS*ADDR_W  packet source
- target_in  in  NUM_PORTS*ADDR_W  destination output port index
- data_in  in  NUM_PORTS*DATA_W  payload
- valid_out  out  NUM_PORTS  output packet valid
- ready_out  in  NUM_PORTS  downstream accepts
- source_out  out  NUM_PORTS*ADDR_W  forwarded source
- target_out  out  NUM_PORTS*ADDR_W  forwarded target; always equals the port index
- data_out  out  NUM_PORTS*DATA_W  forwarded payload
- drop_cnt  out  CNT_W  saturating count of discarded packets

## Operation
- **Accept:** input p accepts on an edge where valid_in[p] && ready_in[p]. ready_in[p] = !full[p], combinational from the FIFO count.
- **Valid target (target < NUM_PORTS):** {source, target, data} is pushed into FIFO p.
- **Invalid target (target ≥ NUM_PORTS):** the packet is still accepted, is not pushed, and drop_cnt increments.
  - When k inputs drop on the same edge, drop_cnt increases by k.
  - drop_cnt saturates at 2^CNT_W−1.
- **Request:** FIFO p requests output t when it is non-empty and its head target is t. Each head has exactly one target, so an input is never granted by two outputs at once.
- **Output register load:** output t loads when !valid_out[t] || ready_out[t].
- **Arbitration:** when output t can load, its arbiter grants the first requesting input at or after rr_ptr[t], scanning ascending with wrap.
  - The granted FIFO pops and its head is written to output register t.
  - rr_ptr[t] becomes (grant+1) mod NUM_PORTS.
  - With no request, valid_out[t] clears if ready_out[t] was high, and rr_ptr[t] holds.
- **Stall:** while valid_out[t] && !ready_out[t], output t's register and rr_ptr[t] hold; no grant is issued for t.
- **Push/pop:** a FIFO may push and pop on the same edge when not full, and the count is unchanged. A full FIFO never pushes (ready_in is low) but may pop.
- **Ordering:** packets from one input to one output leave in arrival order. There is no ordering guarantee across inputs.
- **Head-of-line blocking:** a head blocked on a stalled output blocks its whole FIFO. This is accepted behaviour.

## Timing
- **Reset values (edge with rst_n low):**
  - Outputs: valid_out=0, source_out/target_out/data_out=0, drop_cnt=0.
  - Internal state: all FIFOs empty, all rr_ptr=0.
  - Inputs are ignored on that edge.
  - Reset applied mid-operation discards all FIFO and output contents with no partial packet emitted.
- **ready_in during and after reset:** ready_in equals !full, so all ones while in reset and immediately after.
- **Latency:** a packet accepted at edge E into an empty FIFO, with its output free, is presented with valid_out high from edge E+1. The minimum latency is one cycle.
- **Throughput:** each output delivers one packet per cycle while ready_out stays high. Each input accepts one packet per cycle while not full.
- **Handshake:** a transfer completes on the edge where valid_out && ready_out. Data is stable while valid_out && !ready_out.
- **Backpressure to full:** with output t stalled, an input streaming to t holds ready_in low after FIFO_DEPTH accepts plus 1 (one packet sits in the output register).

## Test plan
- **Reset and single packet:** after reset, check valid_out=0, drop_cnt=0, ready_in=4'hF. Drive port 0 {src=0, tgt=2, data=8'hA5} with ready_out=4'hF → valid_out[2] high exactly one cycle later with {0, 2, 8'hA5}; all other outputs stay 0.
- **Round-robin fairness:** ports 0–3 each send 3 packets to target 1 in the same cycles, ready_out all high → output 1 emits sources in order 0,1,2,3,0,1,2,3,0,1,2,3, back-to-back, 12 cycles total.
- **Backpressure:** hold ready_out[3]=0; port 1 streams to target 3 → 5 packets accepted, then ready_in[1]=0 and data_out[3] stays stable. Release ready_out[3] → all 5 packets emerge in order, one per cycle.
- **Drop counting:** ports 0 and 2 send tgt=4'd9 on the same edge → drop_cnt goes 0→2 and nothing appears on any output. With CNT_W=4, 20 drops → drop_cnt=15.
- **Reset mid-stream:** pull rst_n low for 1 cycle while FIFOs hold data and valid_out=4'hF → next cycle valid_out=0 and ready_in=4'hF; no stale packet appears afterwards.
- **Parallel routing:** permutation 0→3, 1→2, 2→1, 3→0 sent concurrently for 8 cycles → every output delivers one packet per cycle, no stalls, and data matches per source.
